// File: rtl/hamming_secded_readout.sv
// SECDED readout stage for an 8-bit Hamming(12,8)+overall-parity protected word.
// Two-stage valid/ready pipeline: S1 registers the word with its syndrome,
// S2 registers the corrected result. Also produces scrub write-back requests
// and keeps saturating SEC/DED event counters.
module hamming_secded_readout #(
  parameter int unsigned CNT_W    = 8,
  parameter bit          SCRUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [4:0]       in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [3:0]       out_syndrome,
  output logic             scrub_req,
  output logic [7:0]       scrub_data,
  output logic [4:0]       scrub_parity,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Check bits {p8,p4,p2,p1}; data bits sit at code positions 3,5,6,7,9,10,11,12.
  function automatic logic [3:0] calc_chk(input logic [7:0] d);
    logic [3:0] c;
    c[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  // Data bit to invert for a given syndrome; check-bit positions leave data alone.
  function automatic logic [7:0] flip_mask(input logic [3:0] pos);
    logic [7:0] m;
    case (pos)
      4'd3:    m = 8'h01;
      4'd5:    m = 8'h02;
      4'd6:    m = 8'h04;
      4'd7:    m = 8'h08;
      4'd9:    m = 8'h10;
      4'd10:   m = 8'h20;
      4'd11:   m = 8'h40;
      4'd12:   m = 8'h80;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  logic                   s1_valid_q, s1_valid_d;
  logic [7:0]             s1_data_q, s1_data_d;
  logic [3:0]             s1_syn_q, s1_syn_d;
  logic                   s1_ov_q, s1_ov_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [7:0]             s2_data_q, s2_data_d;
  logic                   s2_sec_q, s2_sec_d;
  logic                   s2_ded_q, s2_ded_d;
  logic [3:0]             s2_syn_q, s2_syn_d;
  logic [CNT_W-1:0]       sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]       ded_cnt_q, ded_cnt_d;
  logic                   scrub_req_q, scrub_req_d;
  logic [7:0]             scrub_data_q, scrub_data_d;
  logic [4:0]             scrub_par_q, scrub_par_d;

  logic       adv, s1_load, hs, scrub_ev;
  logic       dec_sec, dec_ded;
  logic [7:0] dec_data;
  logic [3:0] scrub_chk;

  // Pipeline handshake: S2 frees up when empty or drained, S1 when it can move on.
  always_comb begin
    adv      = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || adv;
    s1_load  = in_valid && in_ready;
    hs       = s2_valid_q && out_ready;
    scrub_ev = SCRUB_EN && hs && s2_sec_q;
  end

  // S1: capture the word and compute syndrome and overall parity check.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_ov_d    = s1_ov_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_syn_d   = calc_chk(in_data) ^ in_parity[3:0];
      s1_ov_d    = (^in_data) ^ (^in_parity);
    end else if (s1_valid_q && adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Classify the S1 word and apply single-bit correction.
  always_comb begin
    dec_sec  = s1_ov_q && (s1_syn_q <= 4'd12);
    dec_ded  = (s1_syn_q != 4'd0) && !dec_sec;
    dec_data = dec_sec ? (s1_data_q ^ flip_mask(s1_syn_q)) : s1_data_q;
  end

  // S2: hold the decoded result until the consumer takes it.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sec_d   = s2_sec_q;
    s2_ded_d   = s2_ded_q;
    s2_syn_d   = s2_syn_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = dec_data;
        s2_sec_d  = dec_sec;
        s2_ded_d  = dec_ded;
        s2_syn_d  = s1_syn_q;
      end
    end
  end

  // Saturating event counters; a clear wins over a same-cycle increment.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (clr_counts) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (hs) begin
      if (s2_sec_q && sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (s2_ded_q && ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  // Scrub write-back: one-cycle request after a corrected word leaves, payload held.
  always_comb begin
    scrub_req_d  = scrub_ev;
    scrub_data_d = scrub_data_q;
    scrub_par_d  = scrub_par_q;
    scrub_chk    = calc_chk(s2_data_q);
    if (scrub_ev) begin
      scrub_data_d = s2_data_q;
      scrub_par_d  = {(^s2_data_q) ^ (^scrub_chk), scrub_chk};
    end
  end

  // State registers with synchronous reset; in-flight words are dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_ov_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_sec_q     <= 1'b0;
      s2_ded_q     <= 1'b0;
      s2_syn_q     <= '0;
      sec_cnt_q    <= '0;
      ded_cnt_q    <= '0;
      scrub_req_q  <= 1'b0;
      scrub_data_q <= '0;
      scrub_par_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      s1_ov_q      <= s1_ov_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_sec_q     <= s2_sec_d;
      s2_ded_q     <= s2_ded_d;
      s2_syn_q     <= s2_syn_d;
      sec_cnt_q    <= sec_cnt_d;
      ded_cnt_q    <= ded_cnt_d;
      scrub_req_q  <= scrub_req_d;
      scrub_data_q <= scrub_data_d;
      scrub_par_q  <= scrub_par_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_sec      = s2_valid_q && s2_sec_q;
  assign out_ded      = s2_valid_q && s2_ded_q;
  assign out_syndrome = s2_syn_q;
  assign scrub_req    = scrub_req_q;
  assign scrub_data   = scrub_data_q;
  assign scrub_parity = scrub_par_q;
  assign sec_count    = sec_cnt_q;
  assign ded_count    = ded_cnt_q;

endmodule

// File: tb/tb_hamming_secded_readout.sv
// Scoreboard bench for hamming_secded_readout: directed words from the test plan
// plus randomised words with 0..3 injected bit flips and random backpressure.
module tb_hamming_secded_readout;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic             out_sec, out_ded, scrub_req, clr_counts;
  logic [7:0]       in_data, out_data, scrub_data;
  logic [4:0]       in_parity, scrub_parity;
  logic [3:0]       out_syndrome;
  logic [CNT_W-1:0] sec_count, ded_count;

  always #5 clk = ~clk;

  hamming_secded_readout #(.CNT_W(CNT_W), .SCRUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_syndrome(out_syndrome),
    .scrub_req(scrub_req), .scrub_data(scrub_data), .scrub_parity(scrub_parity),
    .clr_counts(clr_counts), .sec_count(sec_count), .ded_count(ded_count)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sec;
    logic       ded;
    logic [3:0] syn;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: codeword as bits at positions 0..12 ----
  // Position 0 holds the overall parity p0; positions 1..12 are the Hamming code.
  function automatic logic [12:0] pack(input logic [7:0] d, input logic [4:0] p);
    int dp[8];
    logic [12:0] c;
    dp = '{3, 5, 6, 7, 9, 10, 11, 12};
    c = '0;
    c[0] = p[4]; c[1] = p[0]; c[2] = p[1]; c[4] = p[2]; c[8] = p[3];
    for (int i = 0; i < 8; i++) c[dp[i]] = d[i];
    return c;
  endfunction

  function automatic logic [7:0] unpack_d(input logic [12:0] c);
    int dp[8];
    logic [7:0] d;
    dp = '{3, 5, 6, 7, 9, 10, 11, 12};
    for (int i = 0; i < 8; i++) d[i] = c[dp[i]];
    return d;
  endfunction

  function automatic logic [4:0] unpack_p(input logic [12:0] c);
    return {c[0], c[8], c[4], c[2], c[1]};
  endfunction

  function automatic logic [4:0] ref_encode(input logic [7:0] d);
    logic [12:0] c;
    c = pack(d, 5'b0);
    for (int k = 1; k <= 8; k = k * 2) begin
      logic par;
      par = 1'b0;
      for (int pos = 3; pos <= 12; pos++)
        if ((pos & k) != 0 && (pos & (pos - 1)) != 0) par = par ^ c[pos];
      c[k] = par;
    end
    c[0] = ^c[12:1];
    return unpack_p(c);
  endfunction

  // Syndrome is the XOR of the indices of all set code bits; zero for a valid word.
  function automatic exp_t ref_decode(input logic [7:0] d, input logic [4:0] p);
    logic [12:0] c;
    int   syn;
    logic ov;
    exp_t e;
    c = pack(d, p);
    syn = 0;
    for (int pos = 1; pos <= 12; pos++) if (c[pos]) syn = syn ^ pos;
    ov = ^c;
    e.syn  = 4'(syn);
    e.sec  = ov && syn <= 12;
    e.ded  = (syn != 0) && !e.sec;
    e.data = d;
    if (e.sec && syn != 0) begin
      c[syn] = ~c[syn];
      e.data = unpack_d(c);
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic s, input logic dd, input logic [3:0] y);
    exp_t e;
    e.data = d; e.sec = s; e.ded = dd; e.syn = y;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ------------------------------------
  int         mdl_sec = 0, mdl_ded = 0;
  bit         scrub_pend = 1'b0;
  logic [7:0] mdl_sd = '0;
  logic [4:0] mdl_sp = '0;
  bit         prev_rst = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sec, prev_ded;
  logic [3:0] prev_syn;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      mdl_sec = 0; mdl_ded = 0;
      scrub_pend = 1'b0; mdl_sd = '0; mdl_sp = '0;
    end else begin
      if (prev_rst) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_flags", 32'({out_sec, out_ded}), 32'd0);
      end
      check("sec_count", 32'(sec_count), 32'(mdl_sec));
      check("ded_count", 32'(ded_count), 32'(mdl_ded));
      check("scrub_req", 32'(scrub_req), 32'(scrub_pend));
      check("scrub_data", 32'(scrub_data), 32'(mdl_sd));
      check("scrub_parity", 32'(scrub_parity), 32'(mdl_sp));
      check("sec_ded_excl", 32'(out_sec & out_ded), 32'd0);
      if (!out_valid) check("idle_flags", 32'({out_sec, out_ded}), 32'd0);
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_data, out_sec, out_ded, out_syndrome}),
              32'({prev_data, prev_sec, prev_ded, prev_syn}));
      end
      scrub_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got data=%0h with empty scoreboard, expected no output", out_data);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] out data=%h sec=%0d ded=%0d syn=%h (exp %h %0d %0d %h)",
                   out_data, out_sec, out_ded, out_syndrome, e.data, e.sec, e.ded, e.syn);
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_sec", 32'(out_sec), 32'(e.sec));
          check("out_ded", 32'(out_ded), 32'(e.ded));
          check("out_syndrome", 32'(out_syndrome), 32'(e.syn));
          if (e.sec) begin
            scrub_pend = 1'b1;
            mdl_sd = e.data;
            mdl_sp = ref_encode(e.data);
            if (mdl_sec < CNT_MAX) mdl_sec++;
          end
          if (e.ded && mdl_ded < CNT_MAX) mdl_ded++;
        end
      end
      if (clr_counts) begin
        mdl_sec = 0; mdl_ded = 0;
      end
    end
    prev_rst   = rst;
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
    prev_sec   = out_sec;
    prev_ded   = out_ded;
    prev_syn   = out_syndrome;
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [4:0] p, input exp_t e);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    in_valid = 1'b1; in_data = d; in_parity = p;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        step();
        n++;
        if (n > 200) begin
          tests++; fails++;
          $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", n);
          in_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send_ref(input logic [7:0] d, input logic [4:0] p);
    send_word(d, p, ref_decode(d, p));
  endtask

  task automatic gen_word(input int nflip, output logic [7:0] d, output logic [4:0] p);
    logic [12:0] c, used;
    int pos;
    d = 8'($urandom);
    c = pack(d, ref_encode(d));
    used = '0;
    for (int i = 0; i < nflip; i++) begin
      do pos = $urandom_range(0, 12); while (used[pos]);
      used[pos] = 1'b1;
      c[pos] = ~c[pos];
    end
    d = unpack_d(c);
    p = unpack_p(c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d words still pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d, bd[4];
    logic [4:0] p, bp[4];
    int n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_parity = '0;
    out_ready = 1'b1; clr_counts = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Latency: accepted word appears two cycles later.
    send_word(8'h00, 5'b00000, mk(8'h00, 1'b0, 1'b0, 4'h0));
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_data", 32'(out_data), 32'h00);

    // Directed words from the test plan, back-to-back.
    send_word(8'h00, 5'b00000, mk(8'h00, 1'b0, 1'b0, 4'h0));
    send_word(8'hFF, 5'b00011, mk(8'hFF, 1'b0, 1'b0, 4'h0));
    send_word(8'h01, 5'b00000, mk(8'h00, 1'b1, 1'b0, 4'h3));
    send_word(8'h00, 5'b10000, mk(8'h00, 1'b1, 1'b0, 4'h0));
    send_word(8'hFF, 5'b00111, mk(8'hFF, 1'b1, 1'b0, 4'h4));
    send_word(8'h81, 5'b00000, mk(8'h81, 1'b0, 1'b1, 4'hF));
    send_word(8'h00, 5'b01101, mk(8'h00, 1'b0, 1'b1, 4'hD));
    drain();
    check("directed_sec_count", 32'(sec_count), 32'd3);
    check("directed_ded_count", 32'(ded_count), 32'd2);

    // Backpressure: only two words fit while the output is stalled.
    for (int i = 0; i < 4; i++) gen_word(0, bd[i], bp[i]);
    out_ready = 1'b0;
    send_ref(bd[0], bp[0]);
    send_ref(bd[1], bp[1]);
    in_valid = 1'b1; in_data = bd[2]; in_parity = bp[2];
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send_ref(bd[2], bp[2]);
    send_ref(bd[3], bp[3]);
    drain();

    // Saturation of the SEC counter.
    for (int i = 0; i < 300; i++) begin
      gen_word(1, d, p);
      send_ref(d, p);
    end
    drain();
    check("sat_sec_count", 32'(sec_count), 32'(CNT_MAX));

    // Clear coinciding with a SEC handshake.
    out_ready = 1'b0;
    send_word(8'h00, 5'b10000, mk(8'h00, 1'b1, 1'b0, 4'h0));
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("clr_setup_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    check("clr_sec_count", 32'(sec_count), 32'd0);
    check("clr_ded_count", 32'(ded_count), 32'd0);
    drain();

    // Random mix of clean, single, double and triple flips with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      gen_word($urandom_range(0, 3), d, p);
      send_ref(d, p);
    end
    rand_rdy = 1'b0;
    drain();

    // Reset with two words in flight: they must never emerge.
    out_ready = 1'b0;
    gen_word(1, d, p); send_ref(d, p);
    gen_word(2, d, p); send_ref(d, p);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; out_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("midrst_no_leak", 32'(out_valid), 32'd0);

    // Recovery after reset.
    for (int i = 0; i < 8; i++) begin
      gen_word($urandom_range(0, 2), d, p);
      send_ref(d, p);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hamming_secded_readout.md
Name: hamming_secded_readout

Overview:
- Downstream consumer of the Hamming-protected 8-bit universal shift register: takes each parallel read word (parallel_out plus its stored check bits) and runs a SECDED decode.
- Emits corrected data on a valid/ready stream.
- Raises a scrub write-back request with corrected data and regenerated check bits.
- Keeps saturating single-error and double-error counters for fault-injection campaigns.

Parameters:
- CNT_W, 8, width of each saturating error counter.
- SCRUB_EN, 1, 1 = scrub_req generated; 0 = scrub_req tied 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- in_data  in  8  data byte read from register
- in_parity  in  5  stored check bits {p0,p8,p4,p2,p1}
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output
- out_data  out  8  corrected (or raw if DED) byte
- out_sec  out  1  single error corrected in this word
- out_ded  out  1  uncorrectable error in this word
- out_syndrome  out  4  {s8,s4,s2,s1} for this word
- scrub_req  out  1  one-cycle write-back request
- scrub_data  out  8  corrected byte for write-back
- scrub_parity  out  5  regenerated check bits for scrub_data
- clr_counts  in  1  synchronous clear of both counters
- sec_count  out  CNT_W  saturating count of SEC events
- ded_count  out  CNT_W  saturating count of DED events

Behaviour:
- Code layout: Hamming(12,8), positions 1..12.
  - Check bits at positions 1, 2, 4, 8.
  - in_data[0..7] at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - pK = even parity over the data positions whose index has bit K set.
  - p0 = even parity over all 12 bits.
- Syndrome: s = recomputed {p8,p4,p2,p1} XOR received. ov = XOR of all 12 code bits and received p0.
- Classification:
  - s=0, ov=0: clean.
  - ov=1, s=0: p0 itself flipped. SEC, data unchanged.
  - ov=1, s in 1..12: flip position s (data bit corrected only if s is a data position). SEC.
  - ov=1, s in 13..15: DED.
  - s!=0, ov=0: DED, out_data = raw in_data.
- Pipeline: 2 register stages.
  - S1 captures input and computes syndrome/ov.
  - S2 holds corrected result and flags.
  - Latency 2 cycles, in_valid accept to out_valid, with no stall.
- Flow control:
  - adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | adv.
  - S1->S2 transfer when s1_valid & adv.
  - Full throughput of 1 word/cycle with out_ready held high.
  - Output fields are stable while out_valid=1 and out_ready=0.
- out_sec and out_ded are never both 1. Both are 0 when out_valid=0.
- Counters:
  - +1 on output handshake (out_valid & out_ready) with the matching flag. Saturate at 2^CNT_W-1.
  - clr_counts has priority over increment in the same cycle.
- Scrub:
  - On output handshake with out_sec=1 and SCRUB_EN=1: scrub_req=1 for exactly one cycle (the next cycle).
  - scrub_data = out_data and scrub_parity = full encode of it, held until the next scrub event.
  - No scrub on DED or clean words.
- Reset (any cycle, including mid-stream): s1_valid, s2_valid, out_valid, scrub_req, counters, out flags and data all go to 0. In-flight words are discarded. in_ready=1 the cycle after rst deasserts.

Test Plan:
- Clean words: 8'h00/5'b00000 and 8'hFF/5'b00011 streamed back-to-back, out_ready=1 -> out_data 00 then FF, 2-cycle latency, sec/ded=0, syndrome 0, counters 0.
- Single data error: in_data 8'h01, parity 5'b00000 -> out_data 8'h00, out_sec=1, syndrome 4'h3, scrub_req pulse with scrub_data 00 / scrub_parity 00000, sec_count=1.
- Check-bit error: 8'h00 with parity 5'b10000 -> out_data 00, out_sec=1, syndrome 0. Then 8'hFF with 5'b00111 -> out_data FF, syndrome 4'h4, sec_count=2.
- Double error: in_data 8'h81, parity 5'b00000 -> syndrome 4'hF, ov=0, out_ded=1, out_data 8'h81, no scrub_req, ded_count=1.
- Backpressure: 4 words sent with out_ready=0 -> in_ready drops after 2 accepts and outputs are held stable. Releasing out_ready delivers all 4 in order, none lost or duplicated.
- Saturation/clear/reset:
  - 300 SEC words with CNT_W=8 -> sec_count=255.
  - clr_counts together with a SEC handshake -> sec_count=0.
  - rst asserted with 2 words in flight -> out_valid=0 next cycle and neither word emerges.
